// File: rtl/ps2_key_encoder_if.sv
// Event bus from the PS/2 encoder to ps2_key consumers.
// The master drives the event word and status strobes; consumers take the slave modport.
interface ps2_key_encoder_if;
   logic [64:0] ps2_key;
   logic        err_parity;
   logic        err_frame;
   logic        busy;

   modport master (output ps2_key, output err_parity, output err_frame, output busy);
   modport slave  (input  ps2_key, input  err_parity, input  err_frame, input  busy);
endinterface

// File: rtl/ps2_key_encoder.sv
// PS/2 device-to-host deserialiser and scancode sequence assembler producing the ps2_key toggle word.
// Event visible 2 clk_sys after the stop-bit strobe; no backpressure, consumers watch bit [64].
module ps2_key_encoder #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 48000
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   ps2_key_encoder_if.master key_if
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [1:0]    clk_sync, dat_sync;
   logic          clk_filt, clk_filt_q;
   logic [FW-1:0] filt_cnt;
   logic          strobe, dat_bit;

   state_t        state, state_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          par, par_nxt;
   logic [TW-1:0] to_cnt, to_cnt_nxt;
   logic          perr_q, perr_nxt, ferr_q, ferr_nxt, bvld_q, bvld_nxt;

   logic [55:0]   acc;
   logic [63:0]   acc_new;
   logic [2:0]    pend;
   logic [64:0]   key_q;

   // Lines idle high, so the synchronisers and filter come out of reset at 1.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync   <= 2'b11;
         dat_sync   <= 2'b11;
         clk_filt   <= 1'b1;
         clk_filt_q <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         clk_sync   <= {clk_sync[0], ps2_clk_in};
         dat_sync   <= {dat_sync[0], ps2_data_in};
         clk_filt_q <= clk_filt;
         if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   assign strobe  = clk_filt_q & ~clk_filt;
   assign dat_bit = dat_sync[1];

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         bit_idx <= '0;
         shreg   <= '0;
         par     <= 1'b0;
         to_cnt  <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         bvld_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         bit_idx <= bit_idx_nxt;
         shreg   <= shreg_nxt;
         par     <= par_nxt;
         to_cnt  <= to_cnt_nxt;
         perr_q  <= perr_nxt;
         ferr_q  <= ferr_nxt;
         bvld_q  <= bvld_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      par_nxt     = par;
      perr_nxt    = 1'b0;
      ferr_nxt    = 1'b0;
      bvld_nxt    = 1'b0;
      to_cnt_nxt  = (state == S_IDLE) ? '0 : to_cnt + TW'(1);
      if (strobe) begin
         to_cnt_nxt = '0;
         case (state)
            S_IDLE: begin
               if (!dat_bit) begin
                  state_nxt   = S_DATA;
                  bit_idx_nxt = '0;
               end else begin
                  ferr_nxt = 1'b1;
               end
            end
            S_DATA: begin
               shreg_nxt   = {dat_bit, shreg[7:1]};
               bit_idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nxt = S_PARITY;
            end
            S_PARITY: begin
               par_nxt   = dat_bit;
               state_nxt = S_STOP;
            end
            default: begin
               state_nxt = S_IDLE;
               if (!dat_bit)           ferr_nxt = 1'b1;
               else if (^{shreg, par}) bvld_nxt = 1'b1;
               else                    perr_nxt = 1'b1;
            end
         endcase
      end else if (state != S_IDLE && to_cnt == TW'(TIMEOUT - 1)) begin
         ferr_nxt   = 1'b1;
         state_nxt  = S_IDLE;
         to_cnt_nxt = '0;
      end
   end

   // shreg still holds the completed byte here: the next strobe is at least 2*FILTER_LEN cycles away.
   assign acc_new = {acc, shreg};

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         acc   <= '0;
         pend  <= '0;
         key_q <= '0;
      end else if (perr_q || ferr_q) begin
         acc  <= '0;
         pend <= '0;
      end else if (bvld_q) begin
         if (pend != 3'd0) begin
            pend <= pend - 3'd1;
            if (pend == 3'd1) begin
               key_q <= {~key_q[64], acc_new};
               acc   <= '0;
            end else begin
               acc <= acc_new[55:0];
            end
         end else if (shreg == 8'hE1) begin
            pend <= 3'd7;
            acc  <= acc_new[55:0];
         end else if (shreg == 8'hE0 || shreg == 8'hF0) begin
            acc <= acc_new[55:0];
         end else if (acc_new == 64'hE012 || acc_new == 64'hE0F07C) begin
            // PrtScr halves: wait for the rest of the sequence.
            acc <= acc_new[55:0];
         end else begin
            key_q <= {~key_q[64], acc_new};
            acc   <= '0;
         end
      end
   end

   assign key_if.ps2_key    = key_q;
   assign key_if.err_parity = perr_q;
   assign key_if.err_frame  = ferr_q;
   assign key_if.busy       = (state != S_IDLE);

endmodule

// File: doc/ps2_key_encoder.md
Name: ps2_key_encoder

Overview:
- Producer end of the 65-bit `ps2_key` event word that the core's keyboard decoders consume.
- Deserialises the PS/2 device-to-host serial stream (ps2_clk/ps2_data) and assembles multi-byte scancode sequences (E0/F0/E1 prefixes).
- Publishes each completed sequence as one event, flagged by flipping toggle bit [64].
- Sits between the board PS/2 pins and any core-side `ps2_key` consumer, all in the clk_sys domain.

Parameters:
- FILTER_LEN, 8, clk_sys cycles a synchronised ps2_clk level must hold stable before it is accepted (glitch filter).
- TIMEOUT, 48000, clk_sys cycles without an accepted ps2_clk falling edge mid-frame before the frame is aborted (2 ms at 24 MHz).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
- ps2_data_in  in  1  raw PS/2 data line (asynchronous)
- ps2_key  out  65  [64] toggle; [63:0] byte sequence, most recent byte in [7:0]
- err_parity  out  1  one-cycle pulse when a frame has bad odd parity
- err_frame  out  1  one-cycle pulse on bad start bit, bad stop bit, or timeout
- busy  out  1  high while a frame is in progress (start bit seen, stop bit not yet sampled)

Behaviour:
- Reset (async, reset_n=0): ps2_key=0, err_*=0, busy=0, FSM=IDLE, accumulator=0, byte counter=0, sync/filter state = line-high.
- Input conditioning:
  - 2-FF synchroniser on each input.
  - ps2_clk filtered: the accepted level changes only after FILTER_LEN consecutive equal samples.
  - A falling edge of the filtered clock is the sample strobe; data is taken from the synchronised ps2_data on that strobe.
- Frame FSM (one transition per strobe):
  - IDLE: data=0 → DATA (bit index 0, busy=1); data=1 → err_frame pulse, stay IDLE.
  - DATA: shift data in LSB first; after bit 7 → PARITY.
  - PARITY: latch parity bit → STOP.
  - STOP: data=1 and odd parity of 9 bits true → byte valid. data=0 → err_frame. Parity false (stop ok) → err_parity. Either way → IDLE, busy=0.
  - Timeout counter clears on every strobe and counts only while busy. Reaching TIMEOUT → err_frame, IDLE, accumulator cleared.
  - Any error also clears the accumulator and the pending counter; no event is published.
- Sequence assembly. On each valid byte B, one cycle after the STOP strobe:
  - acc <= {acc[55:0], B}.
  - If pending counter > 0: decrement it; publish when it reaches 0.
  - Else if B==E1: set pending=7 (Pause sequence, 8 bytes total, exactly fills 64 bits).
  - Else if B is E0 or F0: hold, do not publish.
  - Else, complete:
    - Hold instead of publishing when the sequence is E0 12 (fake shift, PrtScr make) or E0 F0 7C (PrtScr break first half).
    - Otherwise publish.
- Publish:
  - ps2_key[63:0] <= new acc, ps2_key[64] <= ~ps2_key[64], acc <= 0, all in the same cycle.
  - ps2_key is registered and changes only on a publish; toggle flips exactly once per event.
  - Latency: publish is visible 2 clk_sys cycles after the strobe that sampled the stop bit.
- Resulting words:
  - Plain make: only [7:0] nonzero, [15:8] not F0.
  - Break: [15:8]=F0.
  - Extended break: [23:16]=E0.
  - PrtScr/Pause: [63:24] nonzero, so consumers can filter them out.
- No host-to-device transmission: both PS/2 lines are inputs only.

Test Plan:
- Make key: frame 0x1C (start 0, bits LSB first, parity 0, stop 1) at 12.5 kHz → ps2_key = {1'b1, 64'h1C} two cycles after stop; err_* stay 0.
- Extended break: frames E0, F0, 75 → exactly one toggle flip; ps2_key[63:0]=64'hE0F075. No publish after E0 or after F0.
- Pause: frames E1 14 77 E1 F0 14 F0 77 → one event, [63:0]=64'hE11477E1F014F077.
- PrtScr make: frames E0 12 E0 7C → one event [63:0]=64'hE012E07C. Follow with 1C → a separate event, 64'h1C.
- Errors: frame 0x1C with parity bit flipped → err_parity pulse, toggle unchanged. Then stop clock after 4 data bits for >TIMEOUT cycles → err_frame pulse, busy falls. Then a good 0x29 → event 64'h29.
- Glitch and reset: a 3-cycle low pulse on ps2_clk_in → no strobe, FSM stays IDLE. reset_n low mid-frame → ps2_key=0, busy=0 immediately; the next full frame decodes correctly.
